player2_ctl: RTL
================

# player2_ctl

Movement controller for player 2. It turns synchronised button levels into the `xpos_player2`, `ypos_player2` and `state` values consumed by the player-2 draw stage. Position and state update once per video frame, on the rising edge of `vsync`, so every line of a frame is drawn with the same values. It sits between the input decoder (keyboard/buttons) and the VGA draw chain.

## Interface
- `X_INIT`, 300: horizontal position after reset
- `X_MIN`, 0: left clamp
- `X_MAX`, 760: right clamp (screen width minus sprite width)
- `STEP`, 4: horizontal pixels per frame
- `Y_GROUND`, 100: vertical position when standing
- `JUMP_H`, 80: jump apex height; apex position is `Y_GROUND - JUMP_H`
- `JUMP_STEP`, 4: vertical pixels per frame while jumping

Ports:
- `clk`  in  1  pixel clock
- `rst`  in  1  synchronous, active-high reset
- `vsync`  in  1  vertical sync from the VGA timing chain, asynchronous to the button domain
- `btn_left`  in  1  level, asynchronous
- `btn_right`  in  1  level, asynchronous
- `btn_jump`  in  1  level, asynchronous
- `xpos_player2`  out  12  horizontal position, registered
- `ypos_player2`  out  12  vertical position, registered, unsigned
- `state`  out  State  `IDLE` / `LEFT2` / `RIGHT2`, registered

## Operation
- **Input synchronisation:** `btn_*` and `vsync` each pass through 2-flop synchronisers.
- **Frame tick:** `tick` is a 1-cycle pulse on the rising edge of the synchronised `vsync`.
- **Direction, sampled only on `tick`:**
  - left only → `LEFT2`, `x = max(X_MIN, x - STEP)`
  - right only → `RIGHT2`, `x = min(X_MAX, x + STEP)`
  - neither or both → `IDLE`, x unchanged
- **Wall behaviour:** pressing into a wall keeps `LEFT2`/`RIGHT2` while x stays saturated. Underflow checks are done as comparisons before subtraction; no 12-bit wrap is allowed.
- **Jump FSM (`JumpState`), advances only on `tick`:**
  - `GROUND`: `btn_jump` high → `RISE`. y stays at `Y_GROUND`.
  - `RISE`: `y -= JUMP_STEP`, clamped to `Y_GROUND - JUMP_H`. On reaching the apex → `FALL`.
  - `FALL`: `y += JUMP_STEP`, clamped to `Y_GROUND`. On reaching ground → `GROUND`.
  - Landing tick: the FSM stays in `GROUND` for at least one full tick. A jump held through landing restarts on the following tick, never on the landing tick itself.
- **During a jump:** horizontal movement and `state` continue to update normally.
- **Between ticks:** all outputs hold their values.
- **Reset (including mid-jump):**
  - `xpos_player2 = X_INIT`
  - `ypos_player2 = Y_GROUND`
  - `state = IDLE`
  - jump FSM = `GROUND`
  - all synchroniser and edge flops = 0
  - No tick is generated on the first cycle after reset, even if `vsync` is already high.

## Timing
- **Button latency:** a button change is reflected at the first tick at least 2 cycles after the change.
- **`tick` latency:** `tick` rises 3 cycles after `vsync` rises (2 sync flops plus 1 edge flop).
- **Output update:** outputs change on the clock edge at which `tick` is high, i.e. visible in the cycle after `tick`. All three outputs change in the same cycle.
- **Rate:** at most one position step per frame.
- **`vsync` high for one cycle:** still produces exactly one tick.
- **Steady `vsync`:** a constant `vsync` produces no ticks.

## Structure
- **`state_pkg`:**
  - `State` (existing `IDLE`, `LEFT2`, `RIGHT2`)
  - new `JumpState {GROUND, RISE, FALL}`
- **Sub-module `sync_edge`:** 2-flop synchroniser with optional rising-edge pulse output. It is instantiated once per button and once for `vsync` (edge output used only for `vsync`).
- Clamp arithmetic stays inline in `player2_ctl`.

## Test plan
- **Reset:** after reset release, with no buttons, run 3 frames → x=300, y=100, `state=IDLE`.
- **Right to wall:** hold `btn_right` for 200 frames → x increments by 4 per frame and saturates at 760. `state=RIGHT2` throughout, including when saturated.
- **Left from near wall:** start at x=6, hold `btn_left` → x=2, then 0, then stays 0. `state=LEFT2`.
- **Both buttons:** press left and right together → `state=IDLE`, x unchanged over 5 frames.
- **Jump profile:** pulse `btn_jump` for one frame → y sequence 96, 92, …, 20 (apex, 20 ticks), then 24, …, 100. The FSM is back in `GROUND`; no second jump starts.
- **Held jump and reset:** hold `btn_jump` through landing → one `GROUND` tick at y=100, then `RISE` restarts. Assert `rst` mid-rise → next cycle shows y=100, x=300, `IDLE`.

Source files
------------

// File: rtl/state_pkg.sv
// Shared types and constants for the player-2 movement controller.
// Positions are 12-bit unsigned screen coordinates.
package state_pkg;

   typedef enum logic [1:0] {
      IDLE,
      LEFT2,
      RIGHT2
   } State;

   typedef enum logic [1:0] {
      GROUND,
      RISE,
      FALL
   } JumpState;

   localparam logic [11:0] X_INIT    = 12'd300;
   localparam logic [11:0] X_MIN     = 12'd0;
   localparam logic [11:0] X_MAX     = 12'd760;
   localparam logic [11:0] STEP      = 12'd4;
   localparam logic [11:0] Y_GROUND  = 12'd100;
   localparam logic [11:0] JUMP_H    = 12'd80;
   localparam logic [11:0] JUMP_STEP = 12'd4;
   localparam logic [11:0] Y_APEX    = Y_GROUND - JUMP_H;

endpackage

// File: rtl/player2_ctl_if.sv
// Button/vsync inputs and per-frame position/state outputs of player 2.
// The master side is the input decoder / timing chain, the slave the controller.
interface player2_ctl_if;

   logic                 vsync;
   logic                 btn_left;
   logic                 btn_right;
   logic                 btn_jump;
   logic [11:0]          xpos_player2;
   logic [11:0]          ypos_player2;
   state_pkg::State      state;

   modport master (
      output vsync,
      output btn_left,
      output btn_right,
      output btn_jump,
      input  xpos_player2,
      input  ypos_player2,
      input  state
   );

   modport slave (
      input  vsync,
      input  btn_left,
      input  btn_right,
      input  btn_jump,
      output xpos_player2,
      output ypos_player2,
      output state
   );

endinterface

// File: rtl/sync_edge.sv
// Two-flop synchroniser with an optional registered rising-edge pulse.
// With EDGE=0 the pulse output is tied low and no edge flops are built.
module sync_edge #(
   parameter bit EDGE = 1'b0
) (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q,
   output logic rise
);

   logic s1;
   logic s2;

   always_ff @(posedge clk) begin
      if (rst) begin
         s1 <= 1'b0;
         s2 <= 1'b0;
      end else begin
         s1 <= d;
         s2 <= s1;
      end
   end

   assign q = s2;

   if (EDGE) begin : g_edge
      logic s3;
      always_ff @(posedge clk) begin
         if (rst) begin
            s3   <= 1'b0;
            rise <= 1'b0;
         end else begin
            s3   <= s2;
            rise <= s2 & ~s3;
         end
      end
   end else begin : g_level
      assign rise = 1'b0;
   end

endmodule

// File: rtl/player2_ctl.sv
// Player-2 movement controller: steps x and runs the jump profile once
// per frame, on the synchronised rising edge of vsync.
module player2_ctl
   import state_pkg::*;
(
   input  logic         clk,
   input  logic         rst,
   player2_ctl_if.slave bus
);

   logic       tick;
   logic       left;
   logic       right;
   logic       jump;
   logic       vs_q;
   logic [2:0] rise_unused;

   logic [11:0] x;
   logic [11:0] y;
   State        st;
   JumpState    js;

   sync_edge #(.EDGE(1'b1)) u_vs (
      .clk (clk),
      .rst (rst),
      .d   (bus.vsync),
      .q   (vs_q),
      .rise(tick)
   );

   sync_edge u_left (
      .clk (clk),
      .rst (rst),
      .d   (bus.btn_left),
      .q   (left),
      .rise(rise_unused[0])
   );

   sync_edge u_right (
      .clk (clk),
      .rst (rst),
      .d   (bus.btn_right),
      .q   (right),
      .rise(rise_unused[1])
   );

   sync_edge u_jump (
      .clk (clk),
      .rst (rst),
      .d   (bus.btn_jump),
      .q   (jump),
      .rise(rise_unused[2])
   );

   // Clamps compare before stepping so x/y never wrap.
   always_ff @(posedge clk) begin
      if (rst) begin
         x  <= X_INIT;
         y  <= Y_GROUND;
         st <= IDLE;
         js <= GROUND;
      end else if (tick) begin
         unique case ({left, right})
            2'b10: begin
               st <= LEFT2;
               x  <= (x >= X_MIN + STEP) ? x - STEP : X_MIN;
            end
            2'b01: begin
               st <= RIGHT2;
               x  <= (x <= X_MAX - STEP) ? x + STEP : X_MAX;
            end
            default: st <= IDLE;
         endcase

         unique case (js)
            GROUND: begin
               if (jump) js <= RISE;
            end
            RISE: begin
               if (y <= Y_APEX + JUMP_STEP) begin
                  y  <= Y_APEX;
                  js <= FALL;
               end else begin
                  y <= y - JUMP_STEP;
               end
            end
            FALL: begin
               if (y + JUMP_STEP >= Y_GROUND) begin
                  y  <= Y_GROUND;
                  js <= GROUND;
               end else begin
                  y <= y + JUMP_STEP;
               end
            end
            default: js <= GROUND;
         endcase
      end
   end

   assign bus.xpos_player2 = x;
   assign bus.ypos_player2 = y;
   assign bus.state        = st;

endmodule
